// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// control-flow opcodes and status flag positions.
package fetch_pkg;

    localparam int INSTR_OPC_W = 7;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [INSTR_OPC_W-1:0] DP_OP_MAX = 7'b0111111;
    localparam logic [INSTR_OPC_W-1:0] OP_JMP    = 7'b1000000;
    localparam logic [INSTR_OPC_W-1:0] OP_JEQ    = 7'b1000001;
    localparam logic [INSTR_OPC_W-1:0] OP_JNE    = 7'b1000010;
    localparam logic [INSTR_OPC_W-1:0] OP_JGT    = 7'b1000011;
    localparam logic [INSTR_OPC_W-1:0] OP_JLT    = 7'b1000100;
    localparam logic [INSTR_OPC_W-1:0] OP_JGE    = 7'b1000101;
    localparam logic [INSTR_OPC_W-1:0] OP_JLE    = 7'b1000110;
    localparam logic [INSTR_OPC_W-1:0] OP_JCS    = 7'b1000111;
    localparam logic [INSTR_OPC_W-1:0] OP_JVS    = 7'b1001000;
    localparam logic [INSTR_OPC_W-1:0] OP_HALT   = 7'b1111111;

    localparam int Z_BIT = 3;
    localparam int N_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/fetch_sequencer_branch_eval.sv
// Combinational jump decode: flags whether an opcode is a jump and whether
// it is taken against the current status flags.
module branch_eval
    import fetch_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [3:0]       status,
    output logic             is_jump,
    output logic             taken
);

    logic z, n, c, v;

    assign z = status[Z_BIT];
    assign n = status[N_BIT];
    assign c = status[C_BIT];
    assign v = status[V_BIT];

    always_comb begin
        is_jump = (opcode >= OP_JMP) && (opcode <= OP_JVS);
        taken   = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JEQ:  taken = z;
            OP_JNE:  taken = !z;
            OP_JGT:  taken = !z && !n;
            OP_JLT:  taken = n;
            OP_JGE:  taken = !n;
            OP_JLE:  taken = z || n;
            OP_JCS:  taken = c;
            OP_JVS:  taken = v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch/execute sequencer in front of the control unit;
// resolves jumps locally and stops on HALT until reset.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int OPC_W = 7,
    parameter int K_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [OPC_W+K_W-1:0] imem_rdata,
    input  logic [3:0]           status,
    output logic [OPC_W-1:0]     opcode,
    output logic [K_W-1:0]       literal,
    output logic                 instr_valid,
    output logic                 halted,
    output logic [PC_W-1:0]      pc
);

    localparam int IW = OPC_W + K_W;

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [IW-1:0]   ir, ir_next;
    logic [OPC_W-1:0] ir_opc;
    logic [K_W-1:0]  ir_k;
    logic            is_jump, taken;

    assign ir_opc = ir[IW-1:K_W];
    assign ir_k   = ir[K_W-1:0];

    branch_eval #(.OPC_W(OPC_W)) u_branch_eval (
        .opcode  (ir_opc),
        .status  (status),
        .is_jump (is_jump),
        .taken   (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Status is sampled in EXEC so a jump sees the flags written back by the
    // preceding datapath instruction.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = FETCH;
                if (ir_opc == OP_HALT) begin
                    state_next = HALTED;
                end else if (is_jump && taken) begin
                    pc_next = ir_k[PC_W-1:0];
                end else begin
                    pc_next = pc + PC_W'(1);
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC) && (ir_opc <= DP_OP_MAX);
    assign halted      = (state == HALTED);
    assign opcode      = ir_opc;
    assign literal     = ir_k;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scripted instruction memory with
// programmable wait states and a scoreboard of expected fetches and executes.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [14:0] imem_rdata = '0;
    logic [3:0]  status = 4'b0000;
    logic [6:0]  opcode;
    logic [7:0]  literal;
    logic        instr_valid;
    logic        halted;
    logic [7:0]  pc;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .status      (status),
        .opcode      (opcode),
        .literal     (literal),
        .instr_valid (instr_valid),
        .halted      (halted),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] mem [256];
    int          wait_cfg  = 0;
    int          wait_left = 0;
    int          exp_addr [$];
    logic [14:0] exp_exec [$];
    int          log_addr [$];
    int          log_req  [$];
    int          log_vld  [$];
    int          log_pc   [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 15'h5000;
    endtask

    // Sample outputs on the falling edge, then set up the memory response.
    task automatic step();
        logic [14:0] e;
        int a;
        @(negedge clk);
        log_addr.push_back(int'(imem_addr));
        log_req.push_back(int'(imem_req));
        log_vld.push_back(int'(instr_valid));
        log_pc.push_back(int'(pc));
        if (instr_valid) begin
            check("exec_pending", int'(exp_exec.size() > 0), 1);
            if (exp_exec.size() > 0) begin
                e = exp_exec.pop_front();
                check("exec_opcode", int'(opcode), int'(e[14:8]));
                check("exec_literal", int'(literal), int'(e[7:0]));
            end
        end
        imem_ack = 1'b0;
        if (imem_req) begin
            if (wait_left > 0) begin
                wait_left--;
            end else if (exp_addr.size() > 0) begin
                a = exp_addr.pop_front();
                check("fetch_addr", int'(imem_addr), a);
                imem_rdata = mem[imem_addr];
                imem_ack   = 1'b1;
                if (!imem_rdata[14]) exp_exec.push_back(imem_rdata);
                wait_left = wait_cfg;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        check("rst_pc", int'(pc), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_literal", int'(literal), 0);
        check("rst_valid", int'(instr_valid), 0);
        check("rst_halted", int'(halted), 0);
        exp_addr.delete();
        exp_exec.delete();
        log_addr.delete();
        log_req.delete();
        log_vld.delete();
        log_pc.delete();
        wait_left = wait_cfg;
        rst = 1'b0;
    endtask

    // Drain the expected fetch list, then confirm the sequencer is waiting
    // on the next address with every expected execute seen.
    task automatic run_prog(input string tag, input int final_addr);
        for (int i = 0; i < 300 && exp_addr.size() > 0; i++) step();
        check({tag, "_budget"}, exp_addr.size(), 0);
        repeat (3) step();
        check({tag, "_exec_left"}, exp_exec.size(), 0);
        check({tag, "_stall_req"}, int'(imem_req), 1);
        check({tag, "_next_addr"}, int'(imem_addr), final_addr);
    endtask

    task automatic run_jump(input string tag, input logic [6:0] opc,
                            input logic [3:0] st, input bit tk);
        wait_cfg = 0;
        clear_mem();
        mem[0]    = {opc, 8'h40};
        mem[1]    = {7'b0010001, 8'h11};
        mem[8'h40] = {7'b0011000, 8'h22};
        status = st;
        do_reset();
        exp_addr.push_back(0);
        run_prog(tag, tk ? 8'h40 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int vcount;

        // Back-to-back zero-wait datapath instructions
        clear_mem();
        mem[0] = {7'b0000010, 8'h05};
        mem[1] = {7'b0000110, 8'h03};
        wait_cfg = 0;
        do_reset();
        exp_addr.push_back(0);
        exp_addr.push_back(1);
        run_prog("zw", 2);
        check("zw_addr0", log_addr[0], 0);
        check("zw_addr1", log_addr[1], 0);
        check("zw_addr2", log_addr[2], 1);
        check("zw_addr3", log_addr[3], 1);
        check("zw_addr4", log_addr[4], 2);
        check("zw_vld0", log_vld[0], 0);
        check("zw_vld1", log_vld[1], 1);
        check("zw_vld2", log_vld[2], 0);
        check("zw_vld3", log_vld[3], 1);
        check("zw_vld4", log_vld[4], 0);

        // Three wait states before the acknowledge
        wait_cfg = 3;
        do_reset();
        exp_addr.push_back(0);
        run_prog("ws", 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ws_req%0d", i), log_req[i], 1);
            check($sformatf("ws_addr%0d", i), log_addr[i], 0);
            check($sformatf("ws_pc%0d", i), log_pc[i], 0);
        end
        vcount = 0;
        foreach (log_vld[i]) vcount += log_vld[i];
        check("ws_valid_pulses", vcount, 1);
        check("ws_valid_at4", log_vld[4], 1);

        // JEQ at PC 4, taken and not taken
        wait_cfg = 0;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            for (int i = 0; i < 4; i++) mem[i] = {7'(i + 1), 8'(i * 3)};
            mem[4]     = {7'b1000001, 8'h20};
            mem[5]     = {7'b0000111, 8'h55};
            mem[8'h20] = {7'b0001000, 8'h66};
            status = (pass == 0) ? 4'b1000 : 4'b0000;
            do_reset();
            for (int i = 0; i < 5; i++) exp_addr.push_back(i);
            run_prog(pass == 0 ? "jeq_z1" : "jeq_z0", pass == 0 ? 8'h20 : 5);
        end

        run_jump("jle_n",  7'b1000110, 4'b0100, 1'b1);
        run_jump("jle_0",  7'b1000110, 4'b0000, 1'b0);
        run_jump("jgt_0",  7'b1000011, 4'b0000, 1'b1);
        run_jump("jgt_n",  7'b1000011, 4'b0100, 1'b0);
        run_jump("jgt_z",  7'b1000011, 4'b1000, 1'b0);
        run_jump("jmp",    7'b1000000, 4'b0000, 1'b1);
        run_jump("jne_z",  7'b1000010, 4'b1000, 1'b0);
        run_jump("jlt_n",  7'b1000100, 4'b0100, 1'b1);
        run_jump("jge_n",  7'b1000101, 4'b0100, 1'b0);
        run_jump("jcs_c",  7'b1000111, 4'b0010, 1'b1);
        run_jump("jcs_0",  7'b1000111, 4'b1101, 1'b0);
        run_jump("jvs_v",  7'b1001000, 4'b0001, 1'b1);
        run_jump("nop_op", 7'b1010101, 4'b1111, 1'b0);

        // PC wrap from 8'hFF to 8'h00
        clear_mem();
        mem[0]     = {7'b1000000, 8'hFF};
        mem[8'hFF] = {7'b0000101, 8'h77};
        status = 4'b0000;
        do_reset();
        exp_addr.push_back(0);
        exp_addr.push_back(8'hFF);
        run_prog("wrap", 0);

        // HALT at PC 3
        clear_mem();
        mem[0] = {7'b0000001, 8'h01};
        mem[1] = {7'b0000011, 8'h02};
        mem[2] = {7'b0000100, 8'h04};
        mem[3] = {7'b1111111, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) exp_addr.push_back(i);
        for (int i = 0; i < 40 && exp_addr.size() > 0; i++) step();
        check("halt_budget", exp_addr.size(), 0);
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("halt_flag%0d", i), int'(halted), 1);
            check($sformatf("halt_req%0d", i), int'(imem_req), 0);
            check($sformatf("halt_pc%0d", i), int'(pc), 3);
            check($sformatf("halt_vld%0d", i), int'(instr_valid), 0);
        end
        check("halt_exec_left", exp_exec.size(), 0);

        // Leave halt, then reset asynchronously with a fetch pending at PC 3
        do_reset();
        check("unhalt_flag", int'(halted), 0);
        for (int i = 0; i < 3; i++) exp_addr.push_back(i);
        run_prog("pre_arst", 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", int'(pc), 0);
        check("arst_addr", int'(imem_addr), 0);
        check("arst_halted", int'(halted), 0);
        check("arst_opcode", int'(opcode), 0);
        check("arst_literal", int'(literal), 0);
        @(negedge clk);
        exp_addr.delete();
        exp_exec.delete();
        wait_left = wait_cfg;
        rst = 1'b0;
        exp_addr.push_back(0);
        run_prog("post_arst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and sequencing stage sitting directly upstream of the control unit. Holds the program counter, fetches 15-bit instruction words from instruction memory through a req/ack handshake, and presents the 7-bit opcode and 8-bit literal K to the control unit and datapath. Resolves unconditional and conditional jumps locally against the 4-bit status flags and halts on the HALT opcode.

## Interface
- PC_W, 8, program counter / instruction-memory address width
- OPC_W, 7, opcode width
- K_W, 8, literal width; instruction word = {opcode, K}, width OPC_W+K_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req  out  1  fetch request, held high until acknowledged
- imem_addr  out  PC_W  fetch address, equals PC
- imem_ack  in  1  memory acknowledges; imem_rdata valid in the same cycle
- imem_rdata  in  OPC_W+K_W  instruction word; [14:8] opcode, [7:0] K
- status  in  4  flags from status register: [3]=Z, [2]=N, [1]=C, [0]=V
- opcode  out  OPC_W  registered opcode to control unit
- literal  out  K_W  registered K to datapath
- instr_valid  out  1  one-cycle strobe: opcode/literal form a datapath instruction to execute this cycle
- halted  out  1  high once HALT has been fetched
- pc  out  PC_W  current PC (debug)

## Operation
- States: FETCH, EXEC, HALTED.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack=1: capture imem_rdata into IR, go EXEC. imem_ack=0: stay, PC and IR unchanged.
- EXEC (exactly one cycle): decode IR opcode:
  - 7'b0000000–7'b0111111 (datapath ops): instr_valid=1; PC <= PC+1; go FETCH.
  - 7'b1000000 JMP: PC <= K; 7'b1000001 JEQ (Z); 7'b1000010 JNE (!Z); 7'b1000011 JGT (!Z & !N); 7'b1000100 JLT (N); 7'b1000101 JGE (!N); 7'b1000110 JLE (Z|N); 7'b1000111 JCS (C); 7'b1001000 JVS (V). Taken: PC <= K[PC_W-1:0]; not taken: PC <= PC+1. instr_valid=0. Go FETCH.
  - 7'b1111111 HALT: instr_valid=0, PC unchanged, go HALTED.
  - Any other opcode ≥ 7'b1000000: NOP; PC <= PC+1; instr_valid=0; go FETCH.
- Jump condition uses status as sampled during EXEC (flags already reflect the previous datapath instruction's write-back at its EXEC edge).
- HALTED: halted=1, imem_req=0, instr_valid=0; remains until rst.
- PC+1 wraps modulo 2^PC_W (255 -> 0).
- imem_ack outside FETCH is ignored.

## Timing
- Reset: state=FETCH, PC=0, IR=0, opcode=0, literal=0, instr_valid=0, halted=0, imem_req goes 1 on first cycle after rst deasserts (combinational from state).
- imem_req, imem_addr, instr_valid, halted are Moore outputs of state/PC/IR; opcode/literal driven from IR.
- Zero-wait memory (ack in first FETCH cycle): 2 cycles per instruction, FETCH then EXEC.
- Each wait state adds one FETCH cycle; imem_addr stable throughout.
- New PC visible on imem_addr the cycle after EXEC.
- rst asserted in any state, including mid-FETCH with a pending request: immediate return to reset values; pending fetch abandoned.

## Structure
- Shared package fetch_pkg: state encoding (FETCH, EXEC, HALTED), jump/HALT opcode constants, status bit index constants (Z_BIT=3, N_BIT=2, C_BIT=1, V_BIT=0), DP_OP_MAX boundary (7'b0111111).
- One sub-module: branch_eval — combinational, inputs opcode and status, outputs is_jump and taken.

## Test plan
- Reset then zero-wait memory with words {7'b0000010, 8'h05}, {7'b0000110, 8'h03} at 0,1 -> imem_addr 0,0,1,1,2; instr_valid pulses in cycles 2 and 4 with opcode 02/K 05, then 06/K 03.
- Memory acks after 3 wait cycles -> imem_req and imem_addr=0 held 4 cycles, single instr_valid pulse, no PC change while waiting.
- JEQ K=8'h20 at PC 4 with Z=1 -> next imem_addr 8'h20, instr_valid=0; repeat with Z=0 -> next imem_addr 5.
- JLE with Z=0,N=1 -> taken; JGT with Z=0,N=0 -> taken; JGT with N=1 -> not taken.
- PC=8'hFF holding datapath op -> next imem_addr 8'h00.
- HALT at PC 3 -> halted=1, imem_req=0 forever, pc stays 3; rst pulse mid-FETCH after halt -> pc=0, halted=0, fetch resumes at 0.
